food_unit: RTL and testbench
============================

Name: food_unit

Overview:
- Upstream feeder of the snake datapath.
- Places one food cell on the 64x48 grid using a pseudo-random sequence, and rejects cells the snake body occupies through a query handshake with the top level.
- Detects when the snake head reaches the food, then drives the `grow` input of the snake datapath and keeps a score.
- Clocked on the system clock; moves are signalled by a one-cycle `tick` strobe (the move tick synchronised to clk).

Parameters:
- GRID_W, 64, grid columns; power of two.
- GRID_H, 48, grid rows; must be ≤ 64.
- LFSR_SEED, 16'hACE1, LFSR value at reset; must be non-zero.
- SCORE_W, 10, score counter width.
- MAX_TRIES, 16, consecutive rejected candidates before fallback (only used with FOOD_SCAN_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle strobe, one per snake move
- respawn  in  1  game restart (init_snake); synchronous clear
- head_x  in  7  snake head column
- head_y  in  6  snake head row
- cand_valid  out  1  candidate cell presented for occupancy check
- cand_x  out  7  candidate column
- cand_y  out  6  candidate row
- cand_ack  in  1  occupancy result valid this cycle
- cand_hit  in  1  candidate overlaps a snake segment (qualified by cand_ack)
- food_valid  out  1  food_x/food_y hold a placed food cell
- food_x  out  7  food column
- food_y  out  6  food row
- grow  out  1  request the snake datapath to add a segment
- score  out  SCORE_W  foods eaten

Behaviour:
Reset values:
- state PICK; lfsr = LFSR_SEED; tries = 0.
- cand_valid, food_valid, grow = 0; score = 0; food_x/food_y, cand_x/cand_y = 0.

LFSR:
- 16-bit Galois, right shift, taps 16'hB400; advances only in PICK.

State PICK (one clock):
- lfsr ← next value.
- If next[5:0] < GRID_W and next[11:6] < GRID_H: load cand_x/cand_y from those fields, state ← CHECK.
- Otherwise stay in PICK.

State CHECK:
- cand_valid = 1; cand_x/cand_y are stable until cand_ack.
- On cand_ack with cand_hit = 1: tries++, state ← PICK.
- On cand_ack with cand_hit = 0: food_x/food_y ← candidate, food_valid ← 1, tries ← 0, state ← ACTIVE.
- cand_ack outside CHECK is ignored.

State ACTIVE:
- On tick with head_x == food_x and head_y == food_y:
  - food_valid ← 0.
  - score ← score + 1, saturating at all-ones.
  - grow ← 1.
  - state ← PICK.
- tick without a match has no effect.

grow timing:
- Rises on the edge after the eating tick.
- Stays high through the next tick cycle, falls on the edge after it.
- So a consumer sampling at its next move sees it exactly once.

respawn (synchronous, highest priority):
- state ← PICK, food_valid ← 0, grow ← 0, score ← 0, tries ← 0. The LFSR is not reseeded.
- A simultaneous eat, tick or cand_ack is discarded.

Other rules:
- Pause is implied: with no tick strobes, ACTIVE holds indefinitely.
- Asserting reset mid-handshake drops cand_valid immediately (asynchronous).
- Latency: with cand_ack tied 1 and cand_hit tied 0, food_valid is high after the 2nd rising edge following reset release.

Optional Feature:
FOOD_SCAN_EN
- Defined: when tries reaches MAX_TRIES, PICK stops using the LFSR. The candidate becomes the previous candidate + 1 in raster order (x wraps at GRID_W-1 to 0 with y + 1; y wraps at GRID_H-1 to 0). This repeats until a free cell is found, which guarantees termination whenever a free cell exists. tries resets on placement.
- Undefined: LFSR retries indefinitely; tries is not implemented.

Decomposition:
- Package snake_pkg holds:
  - GRID_W, GRID_H, the X/Y coordinate widths (7/6).
  - Out-of-bounds codes 64/127 and 48/63.
  - The food state encoding (PICK, CHECK, ACTIVE).
  - The LFSR tap constant 16'hB400.
- One sub-module, food_lfsr: seedable 16-bit Galois LFSR with an advance enable.

Test Plan:
- Reset release, cand_ack = 1, cand_hit = 0:
  - cand_x = 48, cand_y = 9 (lfsr 16'hE270).
  - food_valid = 1 and food = (48,9) after the 2nd edge.
- First candidate answered with cand_hit = 1: LFSR advances again; a new in-range candidate is presented; food_valid stays 0.
- Food at (48,9), head = (48,9), tick pulse:
  - grow high from the next edge until the edge after the following tick.
  - score = 1; a new placement starts.
- score preset to 1023 (SCORE_W = 10) and eat: score stays 1023; grow still pulses.
- respawn asserted in the same cycle as an eating tick: grow stays 0, score = 0, state PICK, food_valid = 0.
- FOOD_SCAN_EN, MAX_TRIES = 2, cand_hit = 1 on all LFSR candidates:
  - 3rd candidate equals 2nd candidate + 1 in raster order.
  - A candidate of (63,47) is followed by (0,0).

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game datapath.
// Holds the default grid geometry, coordinate widths, out-of-bounds coordinate codes,
// the food placement state encoding and the food LFSR tap mask.
package snake_pkg;

  localparam int unsigned GRID_W = 64;
  localparam int unsigned GRID_H = 48;

  localparam int unsigned X_W = 7;
  localparam int unsigned Y_W = 6;

  // Coordinates that can never name a grid cell.
  localparam logic [X_W-1:0] X_OOB     = 7'd64;
  localparam logic [X_W-1:0] X_OOB_MAX = 7'd127;
  localparam logic [Y_W-1:0] Y_OOB     = 6'd48;
  localparam logic [Y_W-1:0] Y_OOB_MAX = 6'd63;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    PICK,
    CHECK,
    ACTIVE
  } food_state_e;

endpackage

// File: rtl/food_lfsr.sv
// Seedable 16-bit Galois LFSR, right shift, taps from snake_pkg::LFSR_TAPS.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset, loads SEED
//   advance    step the register to next_value on this edge
//   value      current register contents
//   next_value value the register takes on the next advancing edge
module food_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value,
  output logic [15:0] next_value
);
  import snake_pkg::*;

  always_comb begin
    next_value = {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= SEED;
    end else if (advance) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/food_unit.sv
// Food placement and eating logic for the snake game.
// Picks pseudo-random candidate cells, asks the top level whether the snake occupies
// each one, places the food on the first free cell, then watches the head on every
// move tick. Eating raises grow until the following tick and bumps a saturating score.
// Optional feature macro FOOD_SCAN_EN: after MAX_TRIES consecutive rejected candidates,
// candidates advance in raster order from the last one until a free cell is found.
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   tick                       one-cycle strobe per snake move
//   respawn                    synchronous game restart
//   head_x, head_y             snake head cell
//   cand_valid, cand_x, cand_y candidate cell offered for the occupancy query
//   cand_ack, cand_hit         query answer; cand_hit means the cell is occupied
//   food_valid, food_x, food_y placed food cell
//   grow                       segment request to the snake datapath
//   score                      foods eaten, saturating
module food_unit #(
  parameter int unsigned GRID_W    = snake_pkg::GRID_W,
  parameter int unsigned GRID_H    = snake_pkg::GRID_H,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned SCORE_W   = 10,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               respawn,
  input  logic [6:0]         head_x,
  input  logic [5:0]         head_y,
  output logic               cand_valid,
  output logic [6:0]         cand_x,
  output logic [5:0]         cand_y,
  input  logic               cand_ack,
  input  logic               cand_hit,
  output logic               food_valid,
  output logic [6:0]         food_x,
  output logic [5:0]         food_y,
  output logic               grow,
  output logic [SCORE_W-1:0] score
);
  import snake_pkg::*;

  if (LFSR_SEED == 16'h0000 || GRID_H > 64 || GRID_W > 64 || MAX_TRIES == 0 ||
      (GRID_W & (GRID_W - 1)) != 0) begin : g_bad_params
    $error("food_unit: illegal parameter combination");
  end

  food_state_e state;

  logic [15:0] lfsr_value;
  logic [15:0] lfsr_next;
  logic        lfsr_advance;
  logic [X_W-1:0] pick_x;
  logic [Y_W-1:0] pick_y;
  logic        pick_ok;
  logic        scan_mode;
  logic [X_W-1:0] scan_x;
  logic [Y_W-1:0] scan_y;
  logic        eat;

  // Register state and the top LFSR bits are not needed for cell selection.
  logic [19:0] lfsr_unused;
  assign lfsr_unused = {lfsr_value, lfsr_next[15:12]};

  // A respawn cycle replaces the PICK step, so the LFSR holds then.
  assign lfsr_advance = (state == PICK) && !respawn && !scan_mode;

  food_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .advance    (lfsr_advance),
    .value      (lfsr_value),
    .next_value (lfsr_next)
  );

  assign pick_x  = {1'b0, lfsr_next[5:0]};
  assign pick_y  = lfsr_next[11:6];
  assign pick_ok = (32'(pick_x) < GRID_W) && (32'(pick_y) < GRID_H);

  assign eat = (state == ACTIVE) && tick && (head_x == food_x) && (head_y == food_y);

`ifdef FOOD_SCAN_EN
  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

  logic [TRIES_W-1:0] tries;

  // Saturates at MAX_TRIES so scanning persists until a placement clears it.
  assign scan_mode = (32'(tries) >= MAX_TRIES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tries <= '0;
    end else if (respawn) begin
      tries <= '0;
    end else if (state == CHECK && cand_ack) begin
      if (!cand_hit) begin
        tries <= '0;
      end else if (!scan_mode) begin
        tries <= tries + 1'b1;
      end
    end
  end

  // Next cell in raster order, wrapping at the grid edges.
  always_comb begin
    scan_x = cand_x + 1'b1;
    scan_y = cand_y;
    if (cand_x == X_W'(GRID_W - 1)) begin
      scan_x = '0;
      scan_y = (cand_y == Y_W'(GRID_H - 1)) ? '0 : cand_y + 1'b1;
    end
  end
`else
  assign scan_mode = 1'b0;
  assign scan_x    = cand_x;
  assign scan_y    = cand_y;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PICK;
      cand_valid <= 1'b0;
      cand_x     <= '0;
      cand_y     <= '0;
      food_valid <= 1'b0;
      food_x     <= '0;
      food_y     <= '0;
      grow       <= 1'b0;
      score      <= '0;
    end else if (respawn) begin
      state      <= PICK;
      cand_valid <= 1'b0;
      food_valid <= 1'b0;
      grow       <= 1'b0;
      score      <= '0;
    end else begin
      // grow is held across one full move so the consumer samples it exactly once.
      if (grow && tick) begin
        grow <= 1'b0;
      end
      unique case (state)
        PICK: begin
          if (scan_mode) begin
            cand_x     <= scan_x;
            cand_y     <= scan_y;
            cand_valid <= 1'b1;
            state      <= CHECK;
          end else if (pick_ok) begin
            cand_x     <= pick_x;
            cand_y     <= pick_y;
            cand_valid <= 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (cand_ack) begin
            cand_valid <= 1'b0;
            if (cand_hit) begin
              state <= PICK;
            end else begin
              food_x     <= cand_x;
              food_y     <= cand_y;
              food_valid <= 1'b1;
              state      <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (eat) begin
            food_valid <= 1'b0;
            grow       <= 1'b1;
            if (score != '1) begin
              score <= score + 1'b1;
            end
            state <= PICK;
          end
        end
        default: state <= PICK;
      endcase
    end
  end

endmodule

// File: tb/tb_food_unit.sv
module tb_food_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       respawn = 1'b0;
  logic [6:0] head_x = '0;
  logic [5:0] head_y = '0;
  logic       cand_ack = 1'b0;
  logic       cand_hit = 1'b0;
  logic       cand_valid;
  logic [6:0] cand_x;
  logic [5:0] cand_y;
  logic       food_valid;
  logic [6:0] food_x;
  logic [5:0] food_y;
  logic       grow;
  logic [9:0] score;

  int n_checks = 0;
  int n_fail = 0;

  food_unit #(
    .MAX_TRIES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .respawn    (respawn),
    .head_x     (head_x),
    .head_y     (head_y),
    .cand_valid (cand_valid),
    .cand_x     (cand_x),
    .cand_y     (cand_y),
    .cand_ack   (cand_ack),
    .cand_hit   (cand_hit),
    .food_valid (food_valid),
    .food_x     (food_x),
    .food_y     (food_y),
    .grow       (grow),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 choosing a candidate, 1 waiting for the occupancy answer, 2 food on board
  int m_lfsr, m_phase, m_tries, m_score;
  int m_cx, m_cy, m_fx, m_fy, m_tx, m_ty;
  bit m_cv, m_fv, m_grow;

  function automatic int lfsr_step(input int v);
    return (v >> 1) ^ (((v & 1) != 0) ? 'hB400 : 0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr = 'hACE1; m_phase = 0; m_tries = 0; m_score = 0;
      m_cx = 0; m_cy = 0; m_fx = 0; m_fy = 0;
      m_cv = 0; m_fv = 0; m_grow = 0;
    end else if (respawn) begin
      m_phase = 0; m_tries = 0; m_score = 0;
      m_cv = 0; m_fv = 0; m_grow = 0;
    end else begin
      if (tick && m_grow) m_grow = 0;
      case (m_phase)
        0: begin
`ifdef FOOD_SCAN_EN
          if (m_tries >= 2) begin
            m_cx = m_cx + 1;
            if (m_cx == 64) begin
              m_cx = 0;
              m_cy = (m_cy + 1) % 48;
            end
            m_cv = 1; m_phase = 1;
          end else
`endif
          begin
            m_lfsr = lfsr_step(m_lfsr);
            m_tx = m_lfsr % 64;
            m_ty = (m_lfsr / 64) % 64;
            if (m_tx < 64 && m_ty < 48) begin
              m_cx = m_tx; m_cy = m_ty; m_cv = 1; m_phase = 1;
            end
          end
        end
        1: if (cand_ack) begin
          m_cv = 0;
          if (cand_hit) begin
            m_tries++; m_phase = 0;
          end else begin
            m_fx = m_cx; m_fy = m_cy; m_fv = 1; m_tries = 0; m_phase = 2;
          end
        end
        default: if (tick && int'(head_x) == m_fx && int'(head_y) == m_fy) begin
          m_fv = 0; m_grow = 1; m_phase = 0;
          if (m_score < 1023) m_score++;
        end
      endcase
    end
  end

  // Compare DUT to the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("cand_valid", 32'(cand_valid), 32'(m_cv));
    check("cand_x", 32'(cand_x), m_cx);
    check("cand_y", 32'(cand_y), m_cy);
    check("food_valid", 32'(food_valid), 32'(m_fv));
    check("food_x", 32'(food_x), m_fx);
    check("food_y", 32'(food_y), m_fy);
    check("grow", 32'(grow), 32'(m_grow));
    check("score", 32'(score), m_score);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_food(input string name);
    int k;
    k = 0;
    while (!m_fv && k < 200) begin
      step();
      k++;
    end
    if (!m_fv) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: food not placed within 200 cycles", name);
    end
  endtask

  task automatic eat_once();
    wait_food("eat_wait");
    head_x = 7'(m_fx);
    head_y = 6'(m_fy);
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    int k;
    #1 reset = 1'b1;
    cand_ack = 1'b1;
    cand_hit = 1'b0;
    step();
    check("rst_cand_valid", 32'(cand_valid), 0);
    check("rst_food_valid", 32'(food_valid), 0);
    check("rst_grow", 32'(grow), 0);
    check("rst_score", 32'(score), 0);
    check("rst_food_x", 32'(food_x), 0);
    reset = 1'b0;

    // First placement: lfsr E270 -> candidate (48,9), placed on the 2nd edge.
    step();
    check("first_cand_valid", 32'(cand_valid), 1);
    check("first_cand_x", 32'(cand_x), 48);
    check("first_cand_y", 32'(cand_y), 9);
    step();
    check("first_food_valid", 32'(food_valid), 1);
    check("first_food_x", 32'(food_x), 48);
    check("first_food_y", 32'(food_y), 9);

    // Eat at (48,9); grow holds until the edge after the next tick.
    head_x = 7'd48;
    head_y = 6'd9;
    cand_ack = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("eat_grow", 32'(grow), 1);
    check("eat_score", 32'(score), 1);
    check("eat_food_valid", 32'(food_valid), 0);
    step();
    check("second_cand_x", 32'(cand_x), 56);
    check("second_cand_y", 32'(cand_y), 4);
    step();
    step();
    check("grow_held", 32'(grow), 1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("grow_fall", 32'(grow), 0);

    // Reset mid-handshake drops cand_valid at once; then reject the first candidate.
    reset = 1'b1;
    #1;
    check("async_cand_valid", 32'(cand_valid), 0);
    cand_ack = 1'b1;
    cand_hit = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    check("hit_food_valid", 32'(food_valid), 0);
    check("hit_cand_valid", 32'(cand_valid), 0);
    step();
    check("retry_cand_x", 32'(cand_x), 56);
    check("retry_cand_y", 32'(cand_y), 4);
    check("retry_food_valid", 32'(food_valid), 0);
    cand_hit = 1'b0;
    step();
    check("retry_food_x", 32'(food_x), 56);
    check("retry_food_valid2", 32'(food_valid), 1);

    // respawn in the same cycle as an eating tick.
    head_x = 7'd56;
    head_y = 6'd4;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("pre_respawn_score", 32'(score), 1);
    wait_food("respawn_wait");
    head_x = 7'(m_fx);
    head_y = 6'(m_fy);
    tick = 1'b1;
    respawn = 1'b1;
    step();
    tick = 1'b0;
    respawn = 1'b0;
    check("respawn_grow", 32'(grow), 0);
    check("respawn_score", 32'(score), 0);
    check("respawn_food_valid", 32'(food_valid), 0);
    check("respawn_cand_valid", 32'(cand_valid), 0);

    // Score saturation.
    for (int i = 0; i < 1023; i++) eat_once();
    check("sat_score_max", 32'(score), 1023);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("sat_grow_low", 32'(grow), 0);
    eat_once();
    check("sat_grow_pulse", 32'(grow), 1);
    check("sat_score_hold", 32'(score), 1023);

`ifdef FOOD_SCAN_EN
    // Two rejections switch to raster scan from the last candidate.
    reset = 1'b1;
    cand_ack = 1'b1;
    cand_hit = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    check("scan_cand_x", 32'(cand_x), 57);
    check("scan_cand_y", 32'(cand_y), 4);
    k = 0;
    while (!(m_cv && m_cx == 63 && m_cy == 47) && k < 8000) begin
      step();
      k++;
    end
    if (!(m_cv && m_cx == 63 && m_cy == 47)) begin
      n_checks++;
      n_fail++;
      $display("FAIL scan_wait: scan never reached (63,47)");
    end
    step();
    step();
    check("wrap_cand_valid", 32'(cand_valid), 1);
    check("wrap_cand_x", 32'(cand_x), 0);
    check("wrap_cand_y", 32'(cand_y), 0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
